chord_voice_scheduler: RTL

// - Sits between the song reader and harm_chord_player.
// - Takes a stream of song entries: notes, and waits measured in beats.
// - Allocates each note to a free chord voice and issues that voice's one-cycle load pulse.
// - Tracks per-voice busy state from note_done pulses; counts beats for wait entries.
// - Raises song_done once the last entry is retired and all voices are idle.

---
 rtl/chord_sched_pkg.sv | 26 ++
 rtl/chord_voice_alloc.sv | 87 ++++++++
 rtl/chord_voice_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/chord_sched_pkg.sv
// Shared types and default sizes for the chord voice scheduler.
// Holds the FSM state enum and the latched song-entry record.
package chord_sched_pkg;

  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_NOTE_W     = 6;
  localparam int DEF_DUR_W      = 6;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DISPATCH = 3'd2,
    S_STALL    = 3'd3,
    S_WAIT     = 3'd4,
    S_DRAIN    = 3'd5,
    S_DONE     = 3'd6
  } sched_state_e;

  typedef struct packed {
    logic                  is_wait;
    logic                  last;
    logic [DEF_NOTE_W-1:0] note;
    logic [DEF_DUR_W-1:0]  duration;
  } song_entry_t;

endpackage

// File: rtl/chord_voice_alloc.sv
// Voice allocator: per-voice busy and age registers, lowest-free select and
// oldest-voice select (the latter is used for stealing when VOICE_STEAL_EN is set).
module chord_voice_alloc
  import chord_sched_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] load,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] busy,
  output logic [NUM_VOICES-1:0] grant,
  output logic [NUM_VOICES-1:0] oldest,
  output logic                  any_free
);

  localparam int AGE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] free_grant;
  logic [AGE_W-1:0]      best_age;
  logic                  found;

  // A load in the same cycle as that voice's done keeps it busy.
  always_comb begin
    busy_d = load | (busy_q & ~voice_done);
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_d[i] = age_q[i];
      if (|load) begin
        if (load[i]) begin
          age_d[i] = '0;
        end else if (busy_q[i] && (age_q[i] != AGE_MAX)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_grant = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!busy_q[i] && !found) begin
        free_grant[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    oldest    = '0;
    oldest[0] = 1'b1;
    best_age  = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > best_age) begin
        oldest    = '0;
        oldest[i] = 1'b1;
        best_age  = age_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end

  assign busy     = busy_q;
  assign any_free = ~&busy_q;

`ifdef VOICE_STEAL_EN
  assign grant = any_free ? free_grant : oldest;
`else
  assign grant = free_grant;
`endif

endmodule

// File: rtl/chord_voice_scheduler.sv
// Song-entry scheduler for harm_chord_player: allocates notes to chord voices,
// times wait entries in beats, flags song completion. Option: VOICE_STEAL_EN.
module chord_voice_scheduler
  import chord_sched_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int DUR_W      = DEF_DUR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic                  entry_valid,
  output logic                  entry_ready,
  input  logic                  entry_is_wait,
  input  logic                  entry_last,
  input  logic [NOTE_W-1:0]     entry_note,
  input  logic [DUR_W-1:0]      entry_duration,
  output logic [NUM_VOICES-1:0] load_voice,
  output logic [NOTE_W-1:0]     note_out,
  output logic [DUR_W-1:0]      duration_out,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  activate,
  output logic                  song_done,
  output logic [2:0]            state_dbg,
  output logic [NUM_VOICES-1:0] oldest_dbg
);

  sched_state_e          state_q, state_d;
  song_entry_t           entry_q, entry_d;
  logic [DUR_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  song_done_q, song_done_d;
  logic                  activate_q, activate_d;
  logic [NUM_VOICES-1:0] grant;
  logic                  any_free;
  logic                  can_load;
  sched_state_e          after_entry;

  // Handshake: an entry moves on the rising edge where entry_valid & entry_ready;
  // entry_ready depends only on state and play_enable, never on entry_valid.
  assign entry_ready = (state_q == S_FETCH) && play_enable;

`ifdef VOICE_STEAL_EN
  assign can_load = 1'b1;
`else
  assign can_load = any_free;
`endif

  assign load_voice = ((state_q == S_DISPATCH) && play_enable && can_load) ? grant : '0;

  chord_voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .load       (load_voice),
    .voice_done (voice_done),
    .busy       (voice_busy),
    .grant      (grant),
    .oldest     (oldest_dbg),
    .any_free   (any_free)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    wait_cnt_d  = wait_cnt_q;
    after_entry = entry_q.last ? S_DRAIN : S_FETCH;
    if (play_enable) begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (entry_valid) begin
            entry_d = '{is_wait: entry_is_wait, last: entry_last,
                        note: entry_note, duration: entry_duration};
            if (entry_duration == '0) begin
              state_d = entry_last ? S_DRAIN : S_FETCH;
            end else if (entry_is_wait) begin
              state_d    = S_WAIT;
              wait_cnt_d = entry_duration;
            end else begin
              state_d = S_DISPATCH;
            end
          end
        end
        S_DISPATCH: state_d = (|load_voice) ? after_entry : S_STALL;
        S_STALL:    if (any_free) state_d = S_DISPATCH;
        S_WAIT: begin
          if (beat) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
            if (wait_cnt_q == DUR_W'(1)) state_d = after_entry;
          end
        end
        S_DRAIN:    if (voice_busy == '0) state_d = S_DONE;
        S_DONE:     state_d = S_DONE;
        default:    state_d = S_IDLE;
      endcase
    end
    song_done_d = song_done_q || (state_d == S_DONE);
    activate_d  = play_enable && (|voice_busy);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      entry_q     <= '0;
      wait_cnt_q  <= '0;
      song_done_q <= 1'b0;
      activate_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      wait_cnt_q  <= wait_cnt_d;
      song_done_q <= song_done_d;
      activate_q  <= activate_d;
    end
  end

  assign note_out     = entry_q.note;
  assign duration_out = entry_q.duration;
  assign song_done    = song_done_q;
  assign activate     = activate_q;
  assign state_dbg    = state_q;

endmodule
